// File: rtl/cdb_arbiter_if.sv
// Producer-to-CDB bus: ALU and load result handshakes plus the broadcast side.
// The master side is the producers/snoopers; the slave side is cdb_arbiter.
interface cdb_arbiter_if #(
  parameter int ROB_BIT = 4
);
  logic               alu_valid;
  logic [ROB_BIT-1:0] alu_src;
  logic [31:0]        alu_val;
  logic               alu_ready;
  logic               ld_valid;
  logic [ROB_BIT-1:0] ld_src;
  logic [31:0]        ld_val;
  logic               ld_ready;
  logic               cdb_valid;
  logic [ROB_BIT-1:0] cdb_src;
  logic [31:0]        cdb_val;
  logic               cdb_empty;

  modport master (
    output alu_valid, alu_src, alu_val, ld_valid, ld_src, ld_val,
    input  alu_ready, ld_ready, cdb_valid, cdb_src, cdb_val, cdb_empty
  );

  modport slave (
    input  alu_valid, alu_src, alu_val, ld_valid, ld_src, ld_val,
    output alu_ready, ld_ready, cdb_valid, cdb_src, cdb_val, cdb_empty
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Merges ALU and load results onto the CDB through per-producer FIFOs.
// Define CDB_RR_EN for round-robin on ties; otherwise load has fixed priority.

module cdb_arbiter_fifo #(
  parameter int EW       = 36,
  parameter int FIFO_BIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [EW-1:0] wr_data,
  input  logic          rd_en,
  output logic [EW-1:0] rd_data,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << FIFO_BIT;

  logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [FIFO_BIT-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_BIT:0]        cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wptr_q] = wr_data;
        wptr_d        = wptr_q + FIFO_BIT'(1);
      end
      if (rd_en) rptr_d = rptr_q + FIFO_BIT'(1);
      cnt_d = cnt_q + (FIFO_BIT+1)'(wr_en) - (FIFO_BIT+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the count.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign rd_data = mem_q[rptr_q];
  assign full    = (cnt_q == (FIFO_BIT+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
endmodule

module cdb_arbiter #(
  parameter int ROB_BIT  = 4,
  parameter int FIFO_BIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            rb,
  cdb_arbiter_if.slave    bus
);
  localparam int NP  = 2;
  localparam int ALU = 0;
  localparam int LD  = 1;
  localparam int EW  = ROB_BIT + 32;

  logic [NP-1:0]         in_valid, ready, push, store, nonempty, pop, full, empty;
  logic [NP-1:0][EW-1:0] in_ent, head;
  logic                  go;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [EW-1:0]         cdb_ent_q, cdb_ent_d;

  assign in_valid = {bus.ld_valid, bus.alu_valid};
  assign in_ent   = {{bus.ld_src, bus.ld_val}, {bus.alu_src, bus.alu_val}};
  assign go       = rdy && !rb && !rst;

  for (genvar p = 0; p < NP; p++) begin : g_prod
    assign ready[p]    = !full[p];
    assign nonempty[p] = !empty[p];
    assign push[p]     = in_valid[p] && ready[p] && go;
    // Tag 0 means "no dependency": complete the handshake but drop the result.
    assign store[p]    = push[p] && (in_ent[p][EW-1:32] != '0);

    cdb_arbiter_fifo #(.EW(EW), .FIFO_BIT(FIFO_BIT)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (rb),
      .wr_en   (store[p]),
      .wr_data (in_ent[p]),
      .rd_en   (pop[p]),
      .rd_data (head[p]),
      .full    (full[p]),
      .empty   (empty[p])
    );
  end

`ifdef CDB_RR_EN
  typedef enum logic {GNT_ALU = 1'b0, GNT_LD = 1'b1} gnt_e;
  gnt_e last_q, last_d;

  always_comb begin
    pop = '0;
    if (go) begin
      if (nonempty[ALU] && nonempty[LD]) begin
        if (last_q == GNT_LD) pop[ALU] = 1'b1;
        else                  pop[LD]  = 1'b1;
      end else begin
        pop = nonempty;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (pop[ALU])     last_d = GNT_ALU;
    else if (pop[LD]) last_d = GNT_LD;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= GNT_LD;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    pop = '0;
    if (go) begin
      if (nonempty[LD]) pop[LD]  = 1'b1;
      else              pop[ALU] = nonempty[ALU];
    end
  end
`endif

  // Without a grant the broadcast fields hold; only cdb_valid drops.
  always_comb begin
    cdb_valid_d = |pop;
    cdb_ent_d   = cdb_ent_q;
    if (pop[LD])       cdb_ent_d = head[LD];
    else if (pop[ALU]) cdb_ent_d = head[ALU];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_ent_q   <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_ent_q   <= cdb_ent_d;
    end
  end

  assign bus.alu_ready = ready[ALU];
  assign bus.ld_ready  = ready[LD];
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_src   = cdb_ent_q[EW-1:32];
  assign bus.cdb_val   = cdb_ent_q[31:0];
  assign bus.cdb_empty = empty[ALU] && empty[LD] && !cdb_valid_q;
endmodule
